// File: rtl/riscv_core_amo_sequencer.sv
// RISC-V A-extension sequencer: runs LR/SC/AMO as read and/or write memory
// transactions, maintains the LR reservation and stalls the pipeline meanwhile.
module riscv_core_amo_sequencer (
   input  logic        i_amo_seq_clk,
   input  logic        i_amo_seq_rst_n,
   input  logic        i_amo_seq_start,
   input  logic        i_amo_seq_amo,
   input  logic        i_amo_seq_lr,
   input  logic        i_amo_seq_sc,
   input  logic [3:0]  i_amo_seq_amo_op,
   input  logic        i_amo_seq_dword,
   input  logic [63:0] i_amo_seq_addr,
   input  logic [63:0] i_amo_seq_rs2,
   input  logic        i_amo_seq_snoop_st,
   input  logic [63:0] i_amo_seq_snoop_addr,
   output logic        o_amo_seq_mem_req,
   output logic        o_amo_seq_mem_we,
   output logic [63:0] o_amo_seq_mem_addr,
   output logic [63:0] o_amo_seq_mem_wdata,
   output logic [1:0]  o_amo_seq_mem_size,
   input  logic        i_amo_seq_mem_ack,
   input  logic [63:0] i_amo_seq_mem_rdata,
   output logic        o_amo_seq_stall,
   output logic        o_amo_seq_done,
   output logic [63:0] o_amo_seq_result,
   output logic        o_amo_seq_misaligned
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Word operands arrive sign-extended so one 64-bit datapath serves both widths;
   // only the low half of a word result is written, the upper half forced to zero.
   function automatic logic [63:0] amo_alu(input logic [3:0] op, input logic dw,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [63:0] ax;
      logic [63:0] bx;
      logic [63:0] r;
      logic        lt_s;
      logic        lt_u;
      ax   = dw ? a : {{32{a[31]}}, a[31:0]};
      bx   = dw ? b : {{32{b[31]}}, b[31:0]};
      lt_s = $signed(ax) < $signed(bx);
      lt_u = dw ? (a < b) : (a[31:0] < b[31:0]);
      case (op)
         4'd0:    r = bx;
         4'd1:    r = ax + bx;
         4'd2:    r = ax & bx;
         4'd3:    r = ax | bx;
         4'd4:    r = ax ^ bx;
         4'd5:    r = lt_s ? bx : ax;
         4'd6:    r = lt_s ? ax : bx;
         4'd7:    r = lt_u ? bx : ax;
         4'd8:    r = lt_u ? ax : bx;
         default: r = bx;
      endcase
      return dw ? r : {32'd0, r[31:0]};
   endfunction

   logic [1:0]  state_r;
   logic [1:0]  state_nx_s;
   logic [3:0]  op_r;
   logic        dword_r;
   logic        lr_r;
   logic        sc_r;
   logic        mis_flag_r;
   logic [63:0] addr_r;
   logic [63:0] rs2_r;
   logic [63:0] wdata_r;
   logic [63:0] result_r;
   logic [1:0]  size_r;
   logic        res_valid_r;
   logic [60:0] res_addr_r;

   logic        misalign_s;
   logic        res_match_s;
   logic        accept_s;
   logic [63:0] old_s;
   logic        mem_req_s;
   logic        mem_we_s;
   logic        stall_s;
   logic        done_s;
   logic        mis_out_s;

   assign misalign_s  = i_amo_seq_dword ? (i_amo_seq_addr[2:0] != 3'b000)
                                        : (i_amo_seq_addr[1:0] != 2'b00);
   assign res_match_s = res_valid_r && (res_addr_r == i_amo_seq_addr[63:3]);
   assign accept_s    = (state_r == ST_IDLE) && i_amo_seq_start;
   assign old_s       = dword_r ? i_amo_seq_mem_rdata
                                : {{32{i_amo_seq_mem_rdata[31]}}, i_amo_seq_mem_rdata[31:0]};

   // State register
   always_ff @(posedge i_amo_seq_clk or negedge i_amo_seq_rst_n) begin
      if (!i_amo_seq_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!i_amo_seq_start) begin
               state_nx_s = ST_IDLE;
            end else if (misalign_s) begin
               state_nx_s = ST_DONE;
            end else if (i_amo_seq_sc) begin
               state_nx_s = res_match_s ? ST_WR : ST_DONE;
            end else if (i_amo_seq_lr || i_amo_seq_amo) begin
               state_nx_s = ST_RD;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         ST_RD: begin
            if (i_amo_seq_mem_ack) begin
               state_nx_s = lr_r ? ST_DONE : ST_WR;
            end else begin
               state_nx_s = ST_RD;
            end
         end
         ST_WR: begin
            if (i_amo_seq_mem_ack) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_WR;
            end
         end
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Operand latch, SC/AMO write data and writeback value
   always_ff @(posedge i_amo_seq_clk or negedge i_amo_seq_rst_n) begin
      if (!i_amo_seq_rst_n) begin
         op_r       <= 4'd0;
         dword_r    <= 1'b0;
         lr_r       <= 1'b0;
         sc_r       <= 1'b0;
         mis_flag_r <= 1'b0;
         addr_r     <= 64'd0;
         rs2_r      <= 64'd0;
         wdata_r    <= 64'd0;
         result_r   <= 64'd0;
         size_r     <= 2'b00;
      end else if (accept_s) begin
         op_r       <= i_amo_seq_amo_op;
         dword_r    <= i_amo_seq_dword;
         lr_r       <= i_amo_seq_lr;
         sc_r       <= i_amo_seq_sc;
         mis_flag_r <= misalign_s;
         addr_r     <= i_amo_seq_addr;
         rs2_r      <= i_amo_seq_rs2;
         size_r     <= {1'b1, i_amo_seq_dword};
         result_r   <= {63'd0, i_amo_seq_sc && !misalign_s && !res_match_s};
         wdata_r    <= i_amo_seq_dword ? i_amo_seq_rs2 : {32'd0, i_amo_seq_rs2[31:0]};
      end else if ((state_r == ST_RD) && i_amo_seq_mem_ack) begin
         result_r   <= old_s;
         wdata_r    <= amo_alu(op_r, dword_r, old_s, rs2_r);
      end
   end

   // Reservation tracking; an LR setting it takes priority over a snoop clear
   always_ff @(posedge i_amo_seq_clk or negedge i_amo_seq_rst_n) begin
      if (!i_amo_seq_rst_n) begin
         res_valid_r <= 1'b0;
         res_addr_r  <= 61'd0;
      end else if ((state_r == ST_DONE) && !mis_flag_r && lr_r) begin
         res_valid_r <= 1'b1;
         res_addr_r  <= addr_r[63:3];
      end else if ((state_r == ST_DONE) && !mis_flag_r && sc_r) begin
         res_valid_r <= 1'b0;
      end else if (i_amo_seq_snoop_st && res_valid_r &&
                   (i_amo_seq_snoop_addr[63:3] == res_addr_r)) begin
         res_valid_r <= 1'b0;
      end
   end

   // Output decode from the state register
   always_comb begin
      mem_req_s = 1'b0;
      mem_we_s  = 1'b0;
      stall_s   = 1'b0;
      done_s    = 1'b0;
      mis_out_s = 1'b0;
      case (state_r)
         ST_IDLE: stall_s = i_amo_seq_start && i_amo_seq_rst_n;
         ST_RD: begin
            mem_req_s = 1'b1;
            stall_s   = 1'b1;
         end
         ST_WR: begin
            mem_req_s = 1'b1;
            mem_we_s  = 1'b1;
            stall_s   = 1'b1;
         end
         ST_DONE: begin
            done_s    = 1'b1;
            mis_out_s = mis_flag_r;
         end
         default: begin
            mem_req_s = 1'b0;
            stall_s   = 1'b0;
         end
      endcase
   end

   assign o_amo_seq_mem_req    = mem_req_s;
   assign o_amo_seq_mem_we     = mem_we_s;
   assign o_amo_seq_mem_addr   = addr_r;
   assign o_amo_seq_mem_wdata  = wdata_r;
   assign o_amo_seq_mem_size   = size_r;
   assign o_amo_seq_stall      = stall_s;
   assign o_amo_seq_done       = done_s;
   assign o_amo_seq_result     = result_r;
   assign o_amo_seq_misaligned = mis_out_s;

endmodule

// File: tb/tb_riscv_core_amo_sequencer.sv
// Bench for riscv_core_amo_sequencer: directed scenarios plus random LR/SC/AMO
// traffic against a transaction-level memory and reservation model.
module tb_riscv_core_amo_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0, amo = 1'b0, lr = 1'b0, sc = 1'b0, dword = 1'b0;
   logic [3:0]  amo_op = 4'd0;
   logic [63:0] addr = 64'd0, rs2 = 64'd0, snoop_addr = 64'd0, mem_rdata = 64'd0;
   logic        snoop_st = 1'b0, mem_ack = 1'b0;
   logic        mem_req, mem_we, stall, done, misaligned;
   logic [63:0] mem_addr, mem_wdata, result;
   logic [1:0]  mem_size;

   int          pass_cnt = 0;
   int          total = 0;
   int          step = 0;

   logic [63:0] mem [logic [60:0]];
   bit          res_v = 1'b0;
   logic [60:0] res_a = 61'd0;

   riscv_core_amo_sequencer dut (
      .i_amo_seq_clk(clk), .i_amo_seq_rst_n(rst_n), .i_amo_seq_start(start),
      .i_amo_seq_amo(amo), .i_amo_seq_lr(lr), .i_amo_seq_sc(sc),
      .i_amo_seq_amo_op(amo_op), .i_amo_seq_dword(dword), .i_amo_seq_addr(addr),
      .i_amo_seq_rs2(rs2), .i_amo_seq_snoop_st(snoop_st), .i_amo_seq_snoop_addr(snoop_addr),
      .o_amo_seq_mem_req(mem_req), .o_amo_seq_mem_we(mem_we), .o_amo_seq_mem_addr(mem_addr),
      .o_amo_seq_mem_wdata(mem_wdata), .o_amo_seq_mem_size(mem_size),
      .i_amo_seq_mem_ack(mem_ack), .i_amo_seq_mem_rdata(mem_rdata),
      .o_amo_seq_stall(stall), .o_amo_seq_done(done), .o_amo_seq_result(result),
      .o_amo_seq_misaligned(misaligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         $display("FAIL step %0d %s observed=%h expected=%h", step, tag, obs, exp);
         $error("check %s did not hold", tag);
      end
   endtask

   function automatic logic [63:0] sx(input logic [31:0] w);
      return {{32{w[31]}}, w};
   endfunction

   function automatic logic [63:0] mem_dw(input logic [60:0] k);
      if (!mem.exists(k)) mem[k] = {$urandom(), $urandom()};
      return mem[k];
   endfunction

   task automatic mem_put(input logic [63:0] a, input bit dw, input logic [63:0] v);
      logic [63:0] t;
      t = mem_dw(a[63:3]);
      if (dw) t = v;
      else if (a[2]) t[63:32] = v[31:0];
      else t[31:0] = v[31:0];
      mem[a[63:3]] = t;
   endtask

   // Expected memory image after an AMO, from the instruction semantics.
   function automatic logic [63:0] model_amo(input int op, input bit dw,
                                             input logic [63:0] old, input logic [63:0] b);
      longint unsigned ua, ub, r;
      longint          sa, sb;
      int unsigned     uw, vw, rw;
      int              sw, tw;
      ua = old; ub = b; sa = old; sb = b;
      uw = old[31:0]; vw = b[31:0]; sw = old[31:0]; tw = b[31:0];
      if (dw) begin
         case (op)
            1: r = ua + ub;
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: r = (sa >= sb) ? ua : ub;
            6: r = (sa <= sb) ? ua : ub;
            7: r = (ua >= ub) ? ua : ub;
            8: r = (ua <= ub) ? ua : ub;
            default: r = ub;
         endcase
         return r;
      end
      case (op)
         1: rw = uw + vw;
         2: rw = uw & vw;
         3: rw = uw | vw;
         4: rw = uw ^ vw;
         5: rw = (sw >= tw) ? uw : vw;
         6: rw = (sw <= tw) ? uw : vw;
         7: rw = (uw >= vw) ? uw : vw;
         8: rw = (uw <= vw) ? uw : vw;
         default: rw = vw;
      endcase
      return {32'd0, rw};
   endfunction

   // cls: 0 = AMO, 1 = LR, 2 = SC; dly = wait cycles before each ack
   task automatic run_op(input int cls, input int op, input bit dw,
                         input logic [63:0] a, input logic [63:0] b, input int dly);
      logic [60:0]  k;
      logic [63:0]  old, rsp, ex_wd, ex_res, obs_res, wr_d, wr_a, rd_a;
      logic [31:0]  w;
      logic [130:0] hold;
      logic [1:0]   rd_sz;
      logic         obs_mis;
      bit           mis, seen;
      int           ex_lat, ex_rd, ex_wr, cyc, nrd, nwr, wait_cnt, stall_cnt, unstable, lat;
      step++;
      k = a[63:3];
      old = mem_dw(k);
      w = a[2] ? old[63:32] : old[31:0];
      mis = dw ? (a[2:0] != 3'b000) : (a[1:0] != 2'b00);
      ex_rd = 0; ex_wr = 0; ex_wd = 64'd0; ex_res = 64'd0; ex_lat = 2;
      if (!mis) begin
         case (cls)
            2: begin
               if (res_v && res_a == k) begin
                  ex_wr = 1; ex_wd = dw ? b : {32'd0, b[31:0]}; ex_lat = 3 + dly;
               end else begin
                  ex_res = 64'd1;
               end
               res_v = 1'b0;
            end
            1: begin
               ex_rd = 1; ex_res = dw ? old : sx(w); ex_lat = 3 + dly;
               res_v = 1'b1; res_a = k;
            end
            default: begin
               ex_rd = 1; ex_wr = 1; ex_res = dw ? old : sx(w);
               ex_wd = model_amo(op, dw, dw ? old : {32'd0, w}, b);
               ex_lat = 4 + 2 * dly;
            end
         endcase
      end
      rsp = dw ? old : {$urandom(), w};
      if (ex_wr != 0) mem_put(a, dw, ex_wd);

      @(negedge clk);
      start = 1'b1; amo = (cls == 0); lr = (cls == 1); sc = (cls == 2);
      amo_op = 4'(op); dword = dw; addr = a; rs2 = b;
      #1;
      stall_cnt = stall ? 1 : 0;
      cyc = 1; seen = 1'b0; nrd = 0; nwr = 0; wait_cnt = 0; unstable = 0; lat = 0;
      obs_res = 64'd0; obs_mis = 1'b0; wr_d = 64'd0; wr_a = 64'd0; rd_a = 64'd0;
      rd_sz = 2'b00; hold = '0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         start = 1'b0; amo = 1'b0; lr = 1'b0; sc = 1'b0; mem_ack = 1'b0;
         cyc++;
         #1;
         if (stall) stall_cnt++;
         if (mem_req) begin
            if (wait_cnt == 0) hold = {mem_we, mem_addr, mem_wdata, mem_size};
            else if (hold !== {mem_we, mem_addr, mem_wdata, mem_size}) unstable++;
            if (wait_cnt == dly) begin
               mem_ack = 1'b1;
               if (mem_we) begin
                  nwr++; wr_d = mem_wdata; wr_a = mem_addr;
               end else begin
                  nrd++; rd_a = mem_addr; rd_sz = mem_size; mem_rdata = rsp;
               end
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
         if (done) begin
            seen = 1'b1; lat = cyc; obs_res = result; obs_mis = misaligned;
         end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      chk("done_pulse_width", 64'(done), 64'd0);
      chk("done_seen", 64'(seen), 64'd1);
      chk("latency", 64'(lat), 64'(ex_lat));
      chk("misaligned", 64'(obs_mis), 64'(mis));
      if (!mis) chk("result", obs_res, ex_res);
      chk("read_count", 64'(nrd), 64'(ex_rd));
      chk("write_count", 64'(nwr), 64'(ex_wr));
      if (ex_wr != 0 && nwr == 1) begin
         chk("write_data", wr_d, ex_wd);
         chk("write_addr", wr_a, a);
      end
      if (ex_rd != 0 && nrd == 1) begin
         chk("read_addr", rd_a, a);
         chk("read_size", 64'(rd_sz), dw ? 64'd3 : 64'd2);
      end
      chk("req_stable", 64'(unstable), 64'd0);
      chk("stall_cycles", 64'(stall_cnt), 64'(ex_lat - 1));
   endtask

   task automatic snoop(input logic [63:0] a);
      @(negedge clk);
      snoop_st = 1'b1; snoop_addr = a;
      if (res_v && res_a == a[63:3]) res_v = 1'b0;
      @(negedge clk);
      snoop_st = 1'b0;
   endtask

   initial begin
      int bad;
      logic [63:0] ra;
      int cls_r, idx;
      bit dw_r;

      #2 rst_n = 1'b0;
      #1;
      chk("rst_ctl", 64'({mem_req, mem_we, stall, done, misaligned}), 64'd0);
      chk("rst_addr", mem_addr, 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_size", 64'(mem_size), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // AMOADD.D 0x1000: 5 + 3
      mem_put(64'h1000, 1'b1, 64'd5);
      run_op(0, 1, 1'b1, 64'h1000, 64'd3, 0);
      // LR.W / SC.W pair at 0x2004
      mem_put(64'h2004, 1'b0, 64'hFFFF_FFFF);
      run_op(1, 0, 1'b0, 64'h2004, 64'd0, 0);
      run_op(2, 0, 1'b0, 64'h2004, 64'd7, 0);
      // reservation killed by a snoop in the same dword
      run_op(1, 0, 1'b1, 64'h3000, 64'd0, 1);
      snoop(64'h3004);
      run_op(2, 0, 1'b1, 64'h3000, 64'h55, 0);
      // MINU/MIN word at the sign boundary
      mem_put(64'h5000, 1'b0, 64'h8000_0000);
      run_op(0, 8, 1'b0, 64'h5000, 64'd1, 0);
      mem_put(64'h5000, 1'b0, 64'h8000_0000);
      run_op(0, 6, 1'b0, 64'h5000, 64'd1, 2);
      // misaligned AMOSWAP.D
      run_op(0, 0, 1'b1, 64'h1004, 64'd9, 0);

      // Reset in the middle of an AMO write, after a delayed read ack
      run_op(1, 0, 1'b1, 64'h6000, 64'd0, 0);
      mem_put(64'h7000, 1'b1, 64'h10);
      step++;
      @(negedge clk);
      start = 1'b1; amo = 1'b1; amo_op = 4'd1; dword = 1'b1; addr = 64'h7000; rs2 = 64'h22;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0; amo = 1'b0;
         #1;
         chk("r22_rd_req", 64'({mem_req, mem_we, mem_size}), 64'd11);
         chk("r22_rd_addr", mem_addr, 64'h7000);
         if (i == 3) begin
            mem_ack = 1'b1; mem_rdata = 64'h10;
         end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         #1;
         chk("r22_wr_req", 64'({mem_req, mem_we, mem_size}), 64'd15);
         chk("r22_wr_data", mem_wdata, 64'h32);
      end
      rst_n = 1'b0;
      #1;
      chk("r22_rst_ctl", 64'({mem_req, mem_we, stall, done, misaligned}), 64'd0);
      chk("r22_rst_addr", mem_addr, 64'd0);
      chk("r22_rst_wdata", mem_wdata, 64'd0);
      chk("r22_rst_result", result, 64'd0);
      chk("r22_rst_size", 64'(mem_size), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      res_v = 1'b0;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         #1;
         if (mem_req || done) bad++;
      end
      chk("r22_quiet", 64'(bad), 64'd0);
      run_op(2, 0, 1'b1, 64'h6000, 64'h1, 0);
      run_op(0, 0, 1'b1, 64'h7000, 64'h1, 0);

      // Random traffic over a small dword pool so reservations hit often
      for (int n = 0; n < 60; n++) begin
         cls_r = $urandom_range(0, 2);
         idx = $urandom_range(0, 3);
         dw_r = 1'($urandom_range(0, 1));
         ra = 64'h4000 + 64'(idx * 8);
         if (!dw_r) ra = ra + 64'($urandom_range(0, 1) * 4);
         if ($urandom_range(0, 7) == 0) ra = ra + 64'($urandom_range(1, 3));
         run_op(cls_r, $urandom_range(0, 15), dw_r, ra, {$urandom(), $urandom()},
                $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0)
            snoop(64'h4000 + 64'($urandom_range(0, 31)));
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/riscv_core_amo_sequencer.md
RISCV_CORE_AMO_SEQUENCER -- requirements
Module: riscv_core_amo_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; port order and widths below (i_ = input, o_ = output):
- i_amo_seq_clk  in  1  core clock; all state on rising edge
- i_amo_seq_rst_n  in  1  asynchronous, active-low reset
- i_amo_seq_start  in  1  valid A-extension instruction (opcode 0101111) present in MEM
- i_amo_seq_amo, i_amo_seq_lr, i_amo_seq_sc  in  1 each  decoded class; exactly one set when start=1
- i_amo_seq_amo_op  in  4  0000 SWAP, 0001 ADD, 0010 AND, 0011 OR, 0100 XOR, 0101 MAX, 0110 MIN, 0111 MAXU, 1000 MINU
- i_amo_seq_dword  in  1  funct3[0]: 1 = 64-bit, 0 = 32-bit
- i_amo_seq_addr  in  64  rs1 effective address
- i_amo_seq_rs2  in  64  source operand
- i_amo_seq_snoop_st, i_amo_seq_snoop_addr  in  1, 64  other store committing, and its address
- o_amo_seq_mem_req, o_amo_seq_mem_we  out  1 each  memory request; write enable
- o_amo_seq_mem_addr, o_amo_seq_mem_wdata  out  64 each
- o_amo_seq_mem_size  out  2  10 = word, 11 = dword
- i_amo_seq_mem_ack, i_amo_seq_mem_rdata  in  1, 64  request accepted / read data valid this cycle
- o_amo_seq_stall  out  1  freeze pipeline
- o_amo_seq_done, o_amo_seq_result  out  1, 64  one-cycle completion pulse, rd writeback value
- o_amo_seq_misaligned  out  1  one-cycle address-misaligned exception pulse

Function
REQ-002 SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-003 IDLE and start: latch operands, clear misaligned flag, then:
- misaligned (dword and addr[2:0]!=0, or word and addr[1:0]!=0): go DONE with misaligned flag set
- SC without valid reservation matching addr[63:3]: go DONE, result 1
- SC with matching reservation: go WR
- LR or AMO: go RD
REQ-004 start SHALL be ignored outside IDLE.
REQ-005 RD: mem_req=1, we=0, addr and size from latched operands. On ack, capture rdata (word: bits[31:0] sign-extended to 64); go DONE for LR, WR for AMO.
REQ-006 WR: mem_req=1, we=1. wdata = rs2 for SC, ALU(old, rs2) for AMO; word ops use low 32 bits, upper 32 of wdata zero. On ack go DONE.
REQ-007 Request SHALL stay asserted with stable addr, wdata, size and we until the ack cycle; ack in the first request cycle SHALL be accepted.
REQ-008 MIN/MAX SHALL compare signed, MINU/MAXU unsigned, at the operation width; ADD wraps modulo 2^32 or 2^64.
REQ-009 DONE: done=1 for one cycle; if the misaligned flag is set, also misaligned=1 with no memory access and no reservation change. Then go IDLE.
REQ-010 result: LR/AMO = captured old value; SC = 0 on success, 1 on failure.
REQ-011 stall = (IDLE and start) or RD or WR; stall=0 in DONE.
REQ-012 Zero-wait latency from the start cycle: AMO 4 cycles, LR 3, SC success 3, SC fail or misaligned 2.
REQ-013 Reservation (valid bit plus addr[63:3]):
- set by LR in DONE
- cleared by any SC in DONE, success or fail
- cleared by snoop_st when snoop_addr[63:3] equals the reserved address
- set wins over a snoop clear in the same cycle
REQ-014 Unsupported amo_op codes SHALL behave as SWAP.

Reset
REQ-015 rst_n low SHALL immediately force IDLE and clear the reservation; mem_req, we, stall, done and misaligned drop to 0; addr, wdata and result go to 0; size goes to 00.
REQ-016 Reset during RD or WR SHALL abandon the transaction; no done pulse is produced.

Verification
REQ-017 AMOADD.D, addr 0x1000, mem holds 5, rs2 3, zero-wait ack -> write 8; result 5; done at cycle 4; stall for 3 cycles.
REQ-018 LR.W at 0x2004, mem holds 0xFFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFF; then SC.W to 0x2004 with rs2 7 -> one write of 7, result 0.
REQ-019 LR.D at 0x3000, then snoop_st to 0x3004, then SC.D to 0x3000 -> no memory request, result 1, done 2 cycles after start.
REQ-020 AMOMINU.W with mem 0x8000_0000 and rs2 1 -> writes 1; AMOMIN.W with the same data -> writes 0x8000_0000.
REQ-021 AMOSWAP.D at 0x1004 -> misaligned pulse with done, mem_req never asserted.
REQ-022 Ack delayed 3 cycles in RD, then rst_n pulsed low while in WR -> request outputs hold stable until ack; after reset, IDLE with mem_req=0 and no done pulse.
